// File: rtl/cla_pipe_adder_if.sv
// Operand/result handshake bundle for cla_pipe_adder.
// The sub lane exists only when CLA_PIPE_SUB_EN is defined.
interface cla_pipe_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef CLA_PIPE_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             gout;
  logic             pout;

  modport master (
`ifdef CLA_PIPE_SUB_EN
    output sub,
`endif
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum,
    input  cout, ovf, gout, pout
  );

  modport slave (
`ifdef CLA_PIPE_SUB_EN
    input  sub,
`endif
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum,
    output cout, ovf, gout, pout
  );
endinterface

// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined 4-bit-group carry-lookahead adder.
// Define CLA_PIPE_SUB_EN to add a subtract lane (b inverted, cin flipped).
module cla_pipe_adder #(
  parameter int WIDTH = 16
) (
  input logic              clk,
  input logic              rst_n,
  cla_pipe_adder_if.slave  bus
);
  localparam int NG = WIDTH / 4;

  generate
    if (!(WIDTH == 4 || WIDTH == 8 ||
          WIDTH == 12 || WIDTH == 16)) begin : g_bad_width
      $error("cla_pipe_adder: WIDTH must be 4, 8, 12 or 16");
    end
  endgenerate

  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

`ifdef CLA_PIPE_SUB_EN
  assign b_eff   = bus.b ^ {WIDTH{bus.sub}};
  assign cin_eff = bus.cin ^ bus.sub;
`else
  assign b_eff   = bus.b;
  assign cin_eff = bus.cin;
`endif

  logic [WIDTH-1:0] p_d, g_d;
  logic [NG-1:0]    gg_d, gp_d;

  assign p_d = bus.a ^ b_eff;
  assign g_d = bus.a & b_eff;

  always_comb begin
    gg_d = '0;
    gp_d = '0;
    for (int k = 0; k < NG; k++) begin
      gg_d[k] = g_d[4*k+3]
              | (p_d[4*k+3] & g_d[4*k+2])
              | (p_d[4*k+3] & p_d[4*k+2] & g_d[4*k+1])
              | (p_d[4*k+3] & p_d[4*k+2] & p_d[4*k+1]
                 & g_d[4*k]);
      gp_d[k] = &p_d[4*k +: 4];
    end
  end

  logic             s1_valid_q;
  logic [WIDTH-1:0] p_q, g_q;
  logic [NG-1:0]    gg_q, gp_q;
  logic             c0_q;

  logic             s2_valid_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q, ovf_q, gout_q, pout_q;

  logic s1_adv, s2_adv;

  assign s2_adv = s1_valid_q && (!s2_valid_q || bus.out_ready);
  assign s1_adv = bus.in_valid && (!s1_valid_q || s2_adv);

  assign bus.in_ready = !s1_valid_q || s2_adv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      p_q        <= '0;
      g_q        <= '0;
      gg_q       <= '0;
      gp_q       <= '0;
      c0_q       <= 1'b0;
    end else begin
      if (s1_adv) begin
        s1_valid_q <= 1'b1;
        p_q        <= p_d;
        g_q        <= g_d;
        gg_q       <= gg_d;
        gp_q       <= gp_d;
        c0_q       <= cin_eff;
      end else if (s2_adv) begin
        s1_valid_q <= 1'b0;
      end
    end
  end

  logic [NG:0]      cg;
  logic [WIDTH-1:0] c;
  logic             gw;
  logic             t, pr;

  // Second level: each group carry is a flat OR-of-products over
  // all lower groups rather than a ripple through cg[k].
  always_comb begin
    cg    = '0;
    c     = '0;
    gw    = 1'b0;
    t     = 1'b0;
    pr    = 1'b0;
    cg[0] = c0_q;
    for (int k = 0; k < NG; k++) begin
      t  = gg_q[k];
      pr = gp_q[k];
      for (int j = k - 1; j >= 0; j--) begin
        t  = t | (pr & gg_q[j]);
        pr = pr & gp_q[j];
      end
      gw      = t;
      cg[k+1] = t | (pr & c0_q);
    end
    for (int k = 0; k < NG; k++) begin
      c[4*k]   = cg[k];
      c[4*k+1] = g_q[4*k] | (p_q[4*k] & cg[k]);
      c[4*k+2] = g_q[4*k+1]
               | (p_q[4*k+1] & g_q[4*k])
               | (p_q[4*k+1] & p_q[4*k] & cg[k]);
      c[4*k+3] = g_q[4*k+2]
               | (p_q[4*k+2] & g_q[4*k+1])
               | (p_q[4*k+2] & p_q[4*k+1] & g_q[4*k])
               | (p_q[4*k+2] & p_q[4*k+1] & p_q[4*k]
                  & cg[k]);
    end
  end

  logic [WIDTH-1:0] sum_d;
  logic             cout_d, ovf_d, gout_d, pout_d;

  assign sum_d  = p_q ^ c;
  assign cout_d = cg[NG];
  assign ovf_d  = c[WIDTH-1] ^ cg[NG];
  assign gout_d = gw;
  assign pout_d = &gp_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      sum_q      <= '0;
      cout_q     <= 1'b0;
      ovf_q      <= 1'b0;
      gout_q     <= 1'b0;
      pout_q     <= 1'b0;
    end else begin
      if (s2_adv) begin
        s2_valid_q <= 1'b1;
        sum_q      <= sum_d;
        cout_q     <= cout_d;
        ovf_q      <= ovf_d;
        gout_q     <= gout_d;
        pout_q     <= pout_d;
      end else if (bus.out_ready) begin
        s2_valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid = s2_valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
  assign bus.gout      = gout_q;
  assign bus.pout      = pout_q;
endmodule
